// File: rtl/spi_tx_master.sv
// spi_tx_master
// SPI transmit master. It pops words from a first-word-fall-through FIFO and
// serialises each one onto mosi inside a cs-low frame. The design generates
// spi_clk from sclk. Word width, SPI mode, bit order, clock divider and
// inter-frame gap are all set by parameters.
//
// Ports
//   sclk        in   system clock; all state updates on its rising edge
//   reset_n     in   asynchronous active-low reset
//   enable      in   allows new frames to start (a frame in flight always completes)
//   data_in     in   FIFO head word, valid while fifo_empty is low
//   fifo_empty  in   FIFO empty flag
//   fifo_pop    out  one-cycle pulse consuming the head word, coincident with cs falling
//   spi_clk     out  serial clock, idles at CPOL
//   mosi        out  serial data, 0 outside frames
//   cs          out  chip select, active low
//   busy        out  high in every state except IDLE
//   frame_done  out  one-cycle pulse coincident with cs rising
module spi_tx_master #(
    parameter int DATA_W     = 9,
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 64,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic              sclk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_empty,
    output logic              fifo_pop,
    output logic              spi_clk,
    output logic              mosi,
    output logic              cs,
    output logic              busy,
    output logic              frame_done
);

    localparam int EDGES  = 2 * DATA_W;
    localparam int EDGE_W = $clog2(EDGES + 1);
    localparam int DIV_W  = $clog2(CLK_DIV + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(EDGES);

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                spi_clk_q, spi_clk_d;
    logic                mosi_q, mosi_d;
    logic                cs_q, cs_d;
    logic                fifo_pop_q, fifo_pop_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;

    logic                half_tick;
    logic [EDGE_W-1:0]   edge_num;
    logic                drive_bit;

    // Bit that goes on the wire next, and the register after it has been sent.
    function automatic logic head_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can leave one unassigned and infer a latch.
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        edge_cnt_d   = edge_cnt_q;
        shift_d      = shift_q;
        spi_clk_d    = spi_clk_q;
        mosi_d       = mosi_q;
        cs_d         = cs_q;
        fifo_pop_d   = 1'b0;
        frame_done_d = 1'b0;
        drive_bit    = 1'b0;

        half_tick = (div_cnt_q == DIV_LAST);
        // 1-based number of the spi_clk toggle taken at this half_tick.
        edge_num  = edge_cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    state_d    = LEAD;
                    cs_d       = 1'b0;
                    fifo_pop_d = 1'b1;
                    div_cnt_d  = '0;
                    edge_cnt_d = '0;
                    if (!CPHA) begin
                        // Mode with leading-edge sampling: first bit must be on the wire before any edge.
                        mosi_d  = head_bit(data_in);
                        shift_d = advance(data_in);
                    end else begin
                        shift_d = data_in;
                    end
                end
            end

            LEAD: begin
                if (half_tick) begin
                    div_cnt_d = '0;
                    state_d   = SHIFT;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end

            SHIFT: begin
                if (half_tick) begin
                    div_cnt_d  = '0;
                    spi_clk_d  = ~spi_clk_q;
                    edge_cnt_d = edge_num;
                    // Odd toggles are leading edges, even toggles trailing edges.
                    if (CPHA) begin
                        drive_bit = edge_num[0];
                    end else begin
                        drive_bit = !edge_num[0] && (edge_num != EDGE_LAST);
                    end
                    if (drive_bit) begin
                        mosi_d  = head_bit(shift_q);
                        shift_d = advance(shift_q);
                    end
                    if (edge_num == EDGE_LAST) begin
                        state_d = TRAIL;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end

            TRAIL: begin
                if (half_tick) begin
                    div_cnt_d    = '0;
                    cs_d         = 1'b1;
                    mosi_d       = 1'b0;
                    frame_done_d = 1'b1;
                    gap_cnt_d    = '0;
                    state_d      = GAP;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end

            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            div_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            edge_cnt_q   <= '0;
            shift_q      <= '0;
            spi_clk_q    <= CPOL;
            mosi_q       <= 1'b0;
            cs_q         <= 1'b1;
            fifo_pop_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values computed above.
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            shift_q      <= shift_d;
            spi_clk_q    <= spi_clk_d;
            mosi_q       <= mosi_d;
            cs_q         <= cs_d;
            fifo_pop_q   <= fifo_pop_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign spi_clk    = spi_clk_q;
    assign mosi       = mosi_q;
    assign cs         = cs_q;
    assign fifo_pop   = fifo_pop_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_spi_tx_master.sv
// Testbench for spi_tx_master.
// dut0 uses the default parameters: 9-bit words, mode 0, MSB first, CLK_DIV=2 and GAP_CYCLES=64.
// dut1 uses an 8-bit word, CPOL=1, CPHA=1, LSB first and GAP_CYCLES=4.
// A FIFO model feeds each DUT. The bench pushes every word into the FIFO model
// and queues the word the slave should receive, in wire order with the first bit as the MSB.
// A monitor per DUT captures mosi on each rising spi_clk edge.
// At each cs rise the monitor compares the captured word with the head of the scoreboard queue.
module tb_spi_tx_master;

    logic       sclk = 1'b0;
    logic       reset_n;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;

    // dut0 signals
    logic       en0;
    logic [8:0] din0;
    logic       empty0;
    logic       pop0, sck0, mosi0, cs0, busy0, done0;
    // dut1 signals
    logic       en1;
    logic [7:0] din1;
    logic       empty1;
    logic       pop1, sck1, mosi1, cs1, busy1, done1;

    logic [8:0] fifo0[$];
    logic [7:0] fifo1[$];
    logic [8:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    int frames0 = 0, pop_cnt0 = 0, done_cnt0 = 0, bits0 = 0, busy_cyc0 = 0;
    int frames1 = 0, pop_cnt1 = 0, done_cnt1 = 0;
    int fall_cyc0[$];

    spi_tx_master dut0 (
        .sclk(sclk), .reset_n(reset_n), .enable(en0), .data_in(din0),
        .fifo_empty(empty0), .fifo_pop(pop0), .spi_clk(sck0), .mosi(mosi0),
        .cs(cs0), .busy(busy0), .frame_done(done0)
    );

    spi_tx_master #(
        .DATA_W(8), .CLK_DIV(2), .GAP_CYCLES(4),
        .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)
    ) dut1 (
        .sclk(sclk), .reset_n(reset_n), .enable(en1), .data_in(din1),
        .fifo_empty(empty1), .fifo_pop(pop1), .spi_clk(sck1), .mosi(mosi1),
        .cs(cs1), .busy(busy1), .frame_done(done1)
    );

    initial forever #5 sclk = ~sclk;

    always @(posedge sclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        empty0 = (fifo0.size() == 0);
        din0   = empty0 ? 9'h000 : fifo0[0];
        empty1 = (fifo1.size() == 0);
        din1   = empty1 ? 8'h00 : fifo1[0];
    endtask

    task automatic push0(input logic [8:0] w, input logic [8:0] wire_word);
        fifo0.push_back(w);
        exp_q0.push_back(wire_word);
        refresh();
    endtask

    task automatic push1(input logic [7:0] w, input logic [7:0] wire_word);
        fifo1.push_back(w);
        exp_q1.push_back(wire_word);
        refresh();
    endtask

    // FIFO model: a pop seen in a cycle removes the head before the next edge.
    initial begin : fifo_model
        refresh();
        forever begin
            @(negedge sclk);
            if (reset_n && pop0 && fifo0.size() > 0) fifo0.delete(0);
            if (reset_n && pop1 && fifo1.size() > 0) fifo1.delete(0);
            refresh();
        end
    end

    initial begin : mon0
        logic       prev_clk, prev_cs;
        int         low_len;
        logic [8:0] rx;
        prev_clk = 1'b0; prev_cs = 1'b1; low_len = 0; rx = '0;
        forever begin
            @(negedge sclk);
            if (!reset_n) begin
                bits0 = 0; low_len = 0; rx = '0; prev_cs = 1'b1; prev_clk = sck0;
                continue;
            end
            if (pop0)  pop_cnt0++;
            if (done0) done_cnt0++;
            if (busy0) busy_cyc0++;
            if (!cs0) begin
                low_len++;
                if (prev_cs) fall_cyc0.push_back(cyc);
                if (sck0 && !prev_clk) begin
                    rx = {rx[7:0], mosi0};
                    bits0++;
                end
            end else if (!prev_cs) begin
                check("dut0 frame_done at cs rise", 32'(done0), 32'd1);
                check("dut0 mosi low after frame", 32'(mosi0), 32'd0);
                check("dut0 cs low length", low_len, 32'd40);
                check("dut0 bits per frame", bits0, 32'd9);
                if (exp_q0.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL dut0 unexpected frame: got 0x%0h expected none", rx);
                end else begin
                    check("dut0 received word", 32'(rx), 32'(exp_q0.pop_front()));
                end
                frames0++; bits0 = 0; low_len = 0; rx = '0;
            end
            prev_cs = cs0; prev_clk = sck0;
        end
    end

    initial begin : mon1
        logic       prev_clk, prev_cs;
        int         low_len, nbits;
        logic [7:0] rx;
        prev_clk = 1'b1; prev_cs = 1'b1; low_len = 0; nbits = 0; rx = '0;
        forever begin
            @(negedge sclk);
            if (!reset_n) begin
                nbits = 0; low_len = 0; rx = '0; prev_cs = 1'b1; prev_clk = sck1;
                continue;
            end
            if (pop1)  pop_cnt1++;
            if (done1) done_cnt1++;
            if (!cs1) begin
                low_len++;
                if (sck1 && !prev_clk) begin
                    rx = {rx[6:0], mosi1};
                    nbits++;
                end
            end else if (!prev_cs) begin
                check("dut1 frame_done at cs rise", 32'(done1), 32'd1);
                check("dut1 cs low length", low_len, 32'd36);
                check("dut1 bits per frame", nbits, 32'd8);
                if (exp_q1.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL dut1 unexpected frame: got 0x%0h expected none", rx);
                end else begin
                    check("dut1 received word", 32'(rx), 32'(exp_q1.pop_front()));
                end
                frames1++; nbits = 0; low_len = 0; rx = '0;
            end
            prev_cs = cs1; prev_clk = sck1;
        end
    end

    initial begin : main
        int fr, p0, d0, nf, t0, n;
        reset_n = 1'b0; en0 = 1'b0; en1 = 1'b0;
        repeat (2) @(negedge sclk);
        check("dut0 reset outputs {cs,sck,mosi,pop,busy,done}",
              32'({cs0, sck0, mosi0, pop0, busy0, done0}), 32'b100000);
        check("dut1 reset outputs {cs,sck,mosi,pop,busy,done}",
              32'({cs1, sck1, mosi1, pop1, busy1, done1}), 32'b110000);
        reset_n = 1'b1; en0 = 1'b1; en1 = 1'b1;

        // dut1: mode 3, LSB first. 0x3C goes out as 0,0,1,1,1,1,0,0 and 0x01 as 1 followed by seven 0s.
        push1(8'h3C, 8'h3C);
        push1(8'h01, 8'h80);

        // dut0 sits enabled with an empty FIFO for 500 cycles.
        repeat (500) @(negedge sclk);
        check("dut0 idle: pops", pop_cnt0, 32'd0);
        check("dut0 idle: busy cycles", busy_cyc0, 32'd0);
        check("dut0 idle: {cs,sck}", 32'({cs0, sck0}), 32'b10);
        check("dut1 frames", frames1, 32'd2);
        check("dut1 pops", pop_cnt1, 32'd2);
        check("dut1 frame_done pulses", done_cnt1, 32'd2);
        check("dut1 idle: {cs,sck,busy}", 32'({cs1, sck1, busy1}), 32'b110);

        // A single word starts one cycle after it appears.
        fr = frames0; p0 = pop_cnt0; d0 = done_cnt0; nf = fall_cyc0.size();
        push0(9'h1A5, 9'h1A5);
        t0 = cyc;
        n = 0;
        while (frames0 < fr + 1 && n < 300) begin @(negedge sclk); n++; end
        check("dut0 frame 0x1A5 completed", frames0, fr + 1);
        if (fall_cyc0.size() > nf) check("dut0 start latency from idle", fall_cyc0[nf] - t0, 32'd1);
        check("dut0 pops for one word", pop_cnt0 - p0, 32'd1);
        check("dut0 frame_done for one word", done_cnt0 - d0, 32'd1);

        // Three back-to-back words: frame period 40 + 64 + 1 = 105.
        fr = frames0; p0 = pop_cnt0; d0 = done_cnt0; nf = fall_cyc0.size();
        push0(9'h001, 9'h001);
        push0(9'h0FF, 9'h0FF);
        push0(9'h100, 9'h100);
        n = 0;
        while (frames0 < fr + 3 && n < 600) begin @(negedge sclk); n++; end
        check("dut0 three frames completed", frames0, fr + 3);
        check("dut0 pops for three words", pop_cnt0 - p0, 32'd3);
        check("dut0 frame_done for three words", done_cnt0 - d0, 32'd3);
        if (fall_cyc0.size() >= nf + 3) begin
            check("dut0 frame period 1-2", fall_cyc0[nf + 1] - fall_cyc0[nf], 32'd105);
            check("dut0 frame period 2-3", fall_cyc0[nf + 2] - fall_cyc0[nf + 1], 32'd105);
        end

        // enable drops at bit 4: the frame finishes and no further word is taken.
        fr = frames0; p0 = pop_cnt0; nf = fall_cyc0.size();
        push0(9'h0AA, 9'h0AA);
        push0(9'h155, 9'h155);
        n = 0;
        while (bits0 < 4 && n < 300) begin @(negedge sclk); n++; end
        check("dut0 reached bit 4", bits0, 32'd4);
        en0 = 1'b0;
        n = 0;
        while (frames0 < fr + 1 && n < 300) begin @(negedge sclk); n++; end
        check("dut0 frame after enable drop completed", frames0, fr + 1);
        repeat (300) @(negedge sclk);
        check("dut0 disabled: pops", pop_cnt0 - p0, 32'd1);
        check("dut0 disabled: frames", frames0, fr + 1);
        check("dut0 disabled: {cs,busy}", 32'({cs0, busy0}), 32'b10);
        en0 = 1'b1;
        t0 = cyc;
        n = 0;
        while (frames0 < fr + 2 && n < 300) begin @(negedge sclk); n++; end
        check("dut0 frame after re-enable completed", frames0, fr + 2);
        if (fall_cyc0.size() >= nf + 2) check("dut0 re-enable start latency", fall_cyc0[nf + 1] - t0, 32'd1);

        // Reset at bit 5: outputs return at once, the popped word is dropped.
        fr = frames0;
        push0(9'h0C3, 9'h0C3);
        push0(9'h13C, 9'h13C);
        n = 0;
        while (bits0 < 5 && n < 300) begin @(negedge sclk); n++; end
        check("dut0 reached bit 5", bits0, 32'd5);
        #2 reset_n = 1'b0;
        #1 check("dut0 async reset {cs,sck,mosi,busy}", 32'({cs0, sck0, mosi0, busy0}), 32'b1000);
        if (exp_q0.size() > 0) exp_q0.delete(0);
        repeat (2) @(negedge sclk);
        nf = fall_cyc0.size();
        reset_n = 1'b1;
        t0 = cyc;
        n = 0;
        while (frames0 < fr + 1 && n < 300) begin @(negedge sclk); n++; end
        check("dut0 frame after reset completed", frames0, fr + 1);
        if (fall_cyc0.size() > nf) check("dut0 start latency after reset", fall_cyc0[nf] - t0, 32'd1);

        repeat (80) @(negedge sclk);
        check("dut0 scoreboard drained", exp_q0.size(), 32'd0);
        check("dut1 scoreboard drained", exp_q1.size(), 32'd0);
        check("dut0 FIFO drained", fifo0.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
